conti_link_fifo: RTL and testbench
==================================

Name: conti_link_fifo

Overview:
- Parametrised, buffered successor to the team's flat 32-signal pass-through connector.
- Carries a WIDTH-bit word bundle between clock-module subsystems, e.g. counter core to display/decoder logic.
- Adds a DEPTH-entry show-ahead FIFO and ready/valid handshakes on both sides, so producer and consumer can stall independently.
- Adds synchronous flush and a hold (freeze) control for display-hold features.

Parameters:
- WIDTH, 32, bits per transferred word (≥1).
- DEPTH, 4, number of FIFO entries (power of two, ≥2).
- CW, $clog2(DEPTH+1), width of the count output (derived; not overridden).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO contents.
- hold  in  1  freeze output side; no words are delivered while high.
- in_data  in  WIDTH  producer word.
- in_valid  in  1  producer offers in_data this cycle.
- in_ready  out  1  block can accept a word this cycle.
- out_data  out  WIDTH  head-of-FIFO word.
- out_valid  out  1  out_data is valid and deliverable.
- out_ready  in  1  consumer accepts out_data this cycle.
- count  out  CW  number of stored words, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset, with rst high at a clock edge:
  - write pointer, read pointer and count go to 0;
  - all storage entries go to 0.
  - Outputs after reset: count=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0.
  - rst overrides flush, hold and any handshake in the same cycle.
- Combinational outputs:
  - in_ready = !full; it does not depend on in_valid, out_ready or hold.
  - out_valid = !empty && !hold.
  - out_data = storage[rd_ptr] at all times, including when empty. When empty it shows the last-popped or reset value.
- Push: push = in_valid && in_ready. The word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: pop = out_valid && out_ready. rd_ptr increments modulo DEPTH.
- Count update:
  - push only: count+1.
  - pop only: count−1.
  - push and pop together: count unchanged. This is legal whenever 0<count<DEPTH.
- Latency: a word pushed into an empty FIFO appears on out_data with out_valid=1 in the next cycle. There is no same-cycle bypass.
- Full: in_ready=0, so no push can occur. A pop in that cycle frees one entry, and in_ready=1 from the next cycle. Full never accepts a push in the same cycle as a pop.
- Empty: out_valid=0, so no pop can occur. out_ready is ignored.
- Hold:
  - hold only blocks pops.
  - Pushes continue until full.
  - Contents and order are preserved.
  - Deasserting hold restores out_valid=!empty in the same cycle.
- Flush:
  - With flush=1 and rst=0 at an edge: pointers and count go to 0.
  - Storage contents are not cleared, so out_data shows storage[0] afterwards.
  - A push or pop in the flush cycle is discarded.
  - in_ready and out_valid are still computed normally during the flush cycle. The producer may see a handshake complete, but that word is dropped.
- Ordering: strict FIFO; words are never reordered, duplicated or lost except by flush or rst.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. count alone distinguishes full from empty.

Test Plan:
- Reset then idle. Hold rst for 2 cycles, then release. Required: count=0, empty=1, in_ready=1, out_valid=0, out_data=0.
- Single-word latency (DEPTH=4). Push 0xA5A5_0001 at cycle N with out_ready=1. Required: out_valid=1 and out_data=0xA5A5_0001 at N+1; empty=1 at N+2.
- Fill and drain. With out_ready=0, push 0x1, 0x2, 0x3, 0x4, then attempt 0x5. Required: full=1 and in_ready=0 after the 4th push; 0x5 is not accepted. Then set out_ready=1. Required: outputs 0x1..0x4 in order, then empty=1.
- Simultaneous push and pop with wrap. Keep count=2 while streaming 20 words with in_valid=out_ready=1. Required: count stays 2, the output sequence equals the input sequence, and pointers wrap at least 4 times.
- Hold. With 3 words stored, assert hold for 5 cycles with out_ready=1 and push 1 more word. Required: out_valid=0 throughout and count=4/full=1. On release, all 4 words are delivered in order.
- Flush and reset mid-stream.
  - With count=3, pulse flush together with a push. Required: count=0 next cycle and the pushed word is absent.
  - Repeat with rst=1 and flush=1 together. Required: the full reset values above.

Source files
------------

// File: rtl/conti_link_fifo.sv
// conti_link_fifo: buffered WIDTH-bit word link between clock-module subsystems.
// Show-ahead FIFO with ready/valid on both sides, synchronous flush and an
// output-side hold that freezes delivery without disturbing stored contents.
module conti_link_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_c;
  logic             pop_c;

  // Status and handshake outputs derived from the stored count.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == CW'(0));
  assign count     = count_q;
  assign in_ready  = !full;
  assign out_valid = !empty && !hold;
  assign out_data  = mem_q[rd_ptr_q];
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;

  // Next pointer/count values; flush discards any handshake in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and storage registers; reset also clears storage so out_data reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_c && !flush) mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_conti_link_fifo.sv
// Bench for conti_link_fifo: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_conti_link_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             flush;
  logic             hold;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  conti_link_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .hold      (hold),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: FIFO contents as a queue, plus whether storage was reset.
  logic [WIDTH-1:0] mq[$];
  bit               model_live = 1'b0;
  bit               fresh_reset = 1'b0;
  int unsigned      n_pushed = 0;
  int unsigned      n_popped = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check outputs against the model, advance the model.
  task automatic step(input logic r, input logic f, input logic h, input logic iv,
                      input logic [WIDTH-1:0] d, input logic ordy);
    bit exp_push, exp_pop;
    int unsigned sz;
    rst = r; flush = f; hold = h; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    sz = mq.size();
    if (model_live) begin
      check_eq("count",     64'(count),     64'(sz));
      check_eq("empty",     64'(empty),     64'(sz == 0));
      check_eq("full",      64'(full),      64'(sz == DEPTH));
      check_eq("in_ready",  64'(in_ready),  64'(sz < DEPTH));
      check_eq("out_valid", 64'(out_valid), 64'(sz > 0 && !h));
      if (sz > 0)           check_eq("out_data", 64'(out_data), 64'(mq[0]));
      else if (fresh_reset) check_eq("out_data_rst", 64'(out_data), 64'(0));
    end
    exp_push = iv && (sz < DEPTH);
    exp_pop  = (sz > 0) && !h && ordy;
    @(posedge clk);
    if (r) begin
      mq.delete();
      model_live  = 1'b1;
      fresh_reset = 1'b1;
    end else if (f) begin
      mq.delete();
      fresh_reset = 1'b0;
    end else begin
      if (exp_pop) begin
        void'(mq.pop_front());
        n_popped++;
        fresh_reset = 1'b0;
      end
      if (exp_push) begin
        mq.push_back(d);
        n_pushed++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] w;

    // Reset then idle
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(2);

    // Single-word latency
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1);

    // Fill and drain, including a refused fifth word
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, WIDTH'(i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Streaming at count=2 with pointer wrap
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h101, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, WIDTH'(32'h200 + i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Hold with three stored words and one extra push
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, WIDTH'(32'h300 + i), 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h303, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Flush together with a push at count=3
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, WIDTH'(32'h400 + i), 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h4FF, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h410, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Reset and flush together mid-stream
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, WIDTH'(32'h500 + i), 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h5FF, 1'b1);
    idle(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      w = $urandom;
      step(($urandom_range(99) == 0), ($urandom_range(39) == 0), ($urandom_range(4) == 0),
           ($urandom_range(2) != 0), w, ($urandom_range(2) != 0));
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    check_eq("drained", 64'(empty), 64'(1));
    check_eq("traffic", 64'(n_popped > 100 && n_pushed > 100), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
